// File: rtl/ut_dot_sequencer.sv
// Read sequencer feeding the Ut-row dot-product stage: issues one contiguous
// DPRAM read burst per trigger, aligns operand strobes, then waits for the result.
module ut_dot_sequencer #(
    parameter int  MAX_LEN     = 512,
    parameter int  RD_LAT      = 2,
    parameter int  TIMEOUT_CYC = 1024,
    localparam int ADDR_W      = $clog2(MAX_LEN)
) (
    input  logic              sysClk,
    input  logic              reset,
    input  logic              trig,
    input  logic [9:0]        vec_len,
    input  logic              result_done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              ut_tvalid,
    output logic              vec_tvalid,
    output logic              vec_tlast,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [15:0]       lat_cnt,
    output logic [15:0]       overrun_cnt
);

    localparam int          TW        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [9:0]  MAX_LEN_V = 10'(MAX_LEN);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        DRAIN    = 2'd2,
        WAIT_RES = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [9:0]          len_q, len_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                rd_en_q, rd_en_d;
    logic                last_q, last_d;
    logic [RD_LAT-1:0]   vld_pipe_q, vld_pipe_d;
    logic [RD_LAT-1:0]   lst_pipe_q, lst_pipe_d;
    logic [2:0]          drain_q, drain_d;
    logic [TW-1:0]       wait_q, wait_d;
    logic [15:0]         lat_acc_q, lat_acc_d;
    logic [15:0]         lat_cnt_q, lat_cnt_d;
    logic [15:0]         ovr_q, ovr_d;
    logic [9:0]          len_clip_s;
    logic                done_s;
    logic                timeout_s;

    // Completion strobes land in the cycle result_done is seen, while still in WAIT_RES.
    assign done_s    = (state_q == WAIT_RES) && result_done;
    assign timeout_s = (state_q == WAIT_RES) && !result_done &&
                       (wait_q == TW'(TIMEOUT_CYC - 1));
    assign len_clip_s = (vec_len > MAX_LEN_V) ? MAX_LEN_V : vec_len;

    // Next-state logic for the FSM, strobe pipeline and status counters.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        addr_d     = addr_q;
        rd_en_d    = rd_en_q;
        last_d     = last_q;
        drain_d    = drain_q;
        wait_d     = wait_q;
        lat_acc_d  = lat_acc_q;
        lat_cnt_d  = lat_cnt_q;
        ovr_d      = ovr_q;
        vld_pipe_d = (vld_pipe_q << 1) | RD_LAT'(rd_en_q);
        lst_pipe_d = (lst_pipe_q << 1) | RD_LAT'(last_q);

        if ((state_q != IDLE) && (lat_acc_q != 16'hFFFF)) begin
            lat_acc_d = lat_acc_q + 16'd1;
        end else begin
            lat_acc_d = lat_acc_q;
        end

        if (trig && (state_q != IDLE) && (ovr_q != 16'hFFFF)) begin
            ovr_d = ovr_q + 16'd1;
        end else begin
            ovr_d = ovr_q;
        end

        case (state_q)
            IDLE: begin
                if (trig && (vec_len != 10'd0)) begin
                    state_d   = ISSUE;
                    len_d     = len_clip_s;
                    addr_d    = '0;
                    rd_en_d   = 1'b1;
                    last_d    = (len_clip_s == 10'd1);
                    lat_acc_d = 16'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (last_q) begin
                    state_d = DRAIN;
                    rd_en_d = 1'b0;
                    last_d  = 1'b0;
                    addr_d  = '0;
                    drain_d = 3'd0;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                    last_d = ((10'(addr_q) + 10'd2) == len_q);
                end
            end
            DRAIN: begin
                if (drain_q == 3'(RD_LAT - 1)) begin
                    state_d = WAIT_RES;
                    wait_d  = '0;
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            WAIT_RES: begin
                if (result_done) begin
                    state_d   = IDLE;
                    lat_cnt_d = lat_acc_q;
                end else if (timeout_s) begin
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge sysClk) begin
        if (reset) begin
            state_q    <= IDLE;
            len_q      <= 10'd0;
            addr_q     <= '0;
            rd_en_q    <= 1'b0;
            last_q     <= 1'b0;
            vld_pipe_q <= '0;
            lst_pipe_q <= '0;
            drain_q    <= 3'd0;
            wait_q     <= '0;
            lat_acc_q  <= 16'd0;
            lat_cnt_q  <= 16'd0;
            ovr_q      <= 16'd0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            rd_en_q    <= rd_en_d;
            last_q     <= last_d;
            vld_pipe_q <= vld_pipe_d;
            lst_pipe_q <= lst_pipe_d;
            drain_q    <= drain_d;
            wait_q     <= wait_d;
            lat_acc_q  <= lat_acc_d;
            lat_cnt_q  <= lat_cnt_d;
            ovr_q      <= ovr_d;
        end
    end

    assign rd_en       = rd_en_q;
    assign rd_addr     = addr_q;
    assign ut_tvalid   = vld_pipe_q[RD_LAT-1];
    assign vec_tvalid  = vld_pipe_q[RD_LAT-1];
    assign vec_tlast   = lst_pipe_q[RD_LAT-1];
    assign busy        = (state_q != IDLE);
    assign done        = done_s;
    assign timeout     = timeout_s;
    assign lat_cnt     = lat_cnt_q;
    assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_ut_dot_sequencer.sv
// Directed bench for ut_dot_sequencer: four instances (RD_LAT 1..4) share the
// stimulus and are checked cycle by cycle against hand-derived timing.
module tb_ut_dot_sequencer;

    localparam int MAX_LEN = 512;
    localparam int TO      = 1024;

    logic        sysClk;
    logic        reset;
    logic        trig;
    logic [9:0]  vec_len;
    logic        result_done;

    logic        rd_en_a    [4];
    logic [8:0]  rd_addr_a  [4];
    logic        ut_v_a     [4];
    logic        vec_v_a    [4];
    logic        tlast_a    [4];
    logic        busy_a     [4];
    logic        done_a     [4];
    logic        to_a       [4];
    logic [15:0] lat_a      [4];
    logic [15:0] ovr_a      [4];

    int check_cnt = 0;
    int error_cnt = 0;
    int exp_ovr   = 0;
    int exp_lat   = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        ut_dot_sequencer #(
            .MAX_LEN     (MAX_LEN),
            .RD_LAT      (g + 1),
            .TIMEOUT_CYC (TO)
        ) u_dut (
            .sysClk      (sysClk),
            .reset       (reset),
            .trig        (trig),
            .vec_len     (vec_len),
            .result_done (result_done),
            .rd_en       (rd_en_a[g]),
            .rd_addr     (rd_addr_a[g]),
            .ut_tvalid   (ut_v_a[g]),
            .vec_tvalid  (vec_v_a[g]),
            .vec_tlast   (tlast_a[g]),
            .busy        (busy_a[g]),
            .done        (done_a[g]),
            .timeout     (to_a[g]),
            .lat_cnt     (lat_a[g]),
            .overrun_cnt (ovr_a[g])
        );
    end

    initial sysClk = 1'b0;
    always #5 sysClk = ~sysClk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            error_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All instances idle with no strobes, counters at the bench's expected values.
    task automatic check_quiet(input string tag);
        for (int g = 0; g < 4; g++) begin
            check_value($sformatf("%s_rd_en[L%0d]", tag, g + 1), 32'(rd_en_a[g]), 32'd0);
            check_value($sformatf("%s_rd_addr[L%0d]", tag, g + 1), 32'(rd_addr_a[g]), 32'd0);
            check_value($sformatf("%s_ut_v[L%0d]", tag, g + 1), 32'(ut_v_a[g]), 32'd0);
            check_value($sformatf("%s_vec_v[L%0d]", tag, g + 1), 32'(vec_v_a[g]), 32'd0);
            check_value($sformatf("%s_tlast[L%0d]", tag, g + 1), 32'(tlast_a[g]), 32'd0);
            check_value($sformatf("%s_busy[L%0d]", tag, g + 1), 32'(busy_a[g]), 32'd0);
            check_value($sformatf("%s_done[L%0d]", tag, g + 1), 32'(done_a[g]), 32'd0);
            check_value($sformatf("%s_timeout[L%0d]", tag, g + 1), 32'(to_a[g]), 32'd0);
            check_value($sformatf("%s_lat[L%0d]", tag, g + 1), 32'(lat_a[g]), 32'(exp_lat));
            check_value($sformatf("%s_ovr[L%0d]", tag, g + 1), 32'(ovr_a[g]), 32'(exp_ovr));
        end
    endtask

    // One burst starting in the current cycle T. done_at = cycle offset of
    // result_done (0 = never, expect timeout). ovr_inj adds trigs at T+2..T+4 and T+done_at.
    task automatic burst(input int len_in, input int done_at, input bit ovr_inj);
        int n;
        int c_end;
        int vcount;
        bit trig_now;
        n      = (len_in > MAX_LEN) ? MAX_LEN : len_in;
        c_end  = (done_at != 0) ? done_at : n + 4 + TO;
        vcount = 0;
        trig        = 1'b1;
        vec_len     = 10'(len_in);
        result_done = 1'b0;
        @(negedge sysClk);
        for (int g = 0; g < 4; g++) begin
            check_value($sformatf("busy_at_trig[L%0d]", g + 1), 32'(busy_a[g]), 32'd0);
            check_value($sformatf("lat_at_trig[L%0d]", g + 1), 32'(lat_a[g]), 32'(exp_lat));
        end
        @(posedge sysClk);
        #1;
        for (int c = 1; c <= c_end; c++) begin
            trig_now    = ovr_inj && (c == 2 || c == 3 || c == 4 || c == done_at);
            trig        = trig_now;
            result_done = (c == done_at);
            @(negedge sysClk);
            for (int g = 0; g < 4; g++) begin
                int l;
                bit iss, vld, lst, bsy, to_e, dn_e;
                l    = g + 1;
                iss  = (c <= n);
                vld  = (c >= 1 + l) && (c <= n + l);
                lst  = (c == n + l);
                bsy  = (done_at != 0) ? 1'b1 : (c <= n + l + TO);
                to_e = (done_at == 0) && (c == n + l + TO);
                dn_e = (c == done_at);
                check_value($sformatf("rd_en[L%0d]@%0d", l, c), 32'(rd_en_a[g]), 32'(iss));
                check_value($sformatf("rd_addr[L%0d]@%0d", l, c), 32'(rd_addr_a[g]), iss ? 32'(c - 1) : 32'd0);
                check_value($sformatf("ut_v[L%0d]@%0d", l, c), 32'(ut_v_a[g]), 32'(vld));
                check_value($sformatf("vec_v[L%0d]@%0d", l, c), 32'(vec_v_a[g]), 32'(vld));
                check_value($sformatf("tlast[L%0d]@%0d", l, c), 32'(tlast_a[g]), 32'(lst));
                check_value($sformatf("busy[L%0d]@%0d", l, c), 32'(busy_a[g]), 32'(bsy));
                check_value($sformatf("done[L%0d]@%0d", l, c), 32'(done_a[g]), 32'(dn_e));
                check_value($sformatf("timeout[L%0d]@%0d", l, c), 32'(to_a[g]), 32'(to_e));
                check_value($sformatf("lat[L%0d]@%0d", l, c), 32'(lat_a[g]), 32'(exp_lat));
                check_value($sformatf("ovr[L%0d]@%0d", l, c), 32'(ovr_a[g]), 32'(exp_ovr));
            end
            if (ut_v_a[1]) vcount++;
            if (trig_now && exp_ovr < 65535) exp_ovr++;
            @(posedge sysClk);
            #1;
        end
        trig        = 1'b0;
        result_done = 1'b0;
        check_value($sformatf("valid_count_len%0d", len_in), 32'(vcount), 32'(n));
        if (done_at != 0) exp_lat = done_at;
    endtask

    initial begin
        reset       = 1'b1;
        trig        = 1'b0;
        vec_len     = 10'd0;
        result_done = 1'b0;
        repeat (3) @(posedge sysClk);
        #1;
        reset = 1'b0;
        @(negedge sysClk);
        check_quiet("reset");
        @(posedge sysClk);
        #1;

        // Basic burst: len 4, result_done at T+20 -> lat_cnt 20
        burst(4, 20, 1'b0);
        // Over-length request clipped to 512
        burst(600, 530, 1'b0);
        // Overrun: three trigs during ISSUE plus one in the done cycle
        burst(16, 40, 1'b0 | 1'b1);
        // Trig in the cycle right after done is accepted
        burst(4, 20, 1'b0);
        // Timeout: lat_cnt keeps its last value
        burst(8, 0, 1'b0);
        // Single element: valid and tlast together
        burst(1, 15, 1'b0);

        // Zero-length trig is ignored
        trig    = 1'b1;
        vec_len = 10'd0;
        @(posedge sysClk);
        #1;
        trig = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge sysClk);
            check_quiet($sformatf("zero_len%0d", i));
            @(posedge sysClk);
            #1;
        end

        // Reset while issuing element 5 of 16
        trig    = 1'b1;
        vec_len = 10'd16;
        @(posedge sysClk);
        #1;
        trig = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c == 6) reset = 1'b1;
            @(negedge sysClk);
            check_value($sformatf("rst_pre_addr@%0d", c), 32'(rd_addr_a[0]), 32'(c - 1));
            check_value($sformatf("rst_pre_en@%0d", c), 32'(rd_en_a[0]), 32'd1);
            @(posedge sysClk);
            #1;
        end
        reset   = 1'b0;
        exp_ovr = 0;
        exp_lat = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge sysClk);
            check_quiet($sformatf("post_rst%0d", i));
            @(posedge sysClk);
            #1;
        end
        // Clean restart from address 0 after reset
        burst(3, 12, 1'b0);

        $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
        $finish;
    end

endmodule

// File: doc/ut_dot_sequencer.md
Name: ut_dot_sequencer

Overview:
- Read sequencer placed directly upstream of the Ut-row dot-product stage (the V DPRAM, floating multiply and accumulate).
- On each trigger it issues one burst of DPRAM read addresses. The same addresses drive the Ut DPRAM and the external error-vector RAM.
- It produces the valid and tlast strobes for both multiplier operands, aligned to the RAM read latency.
- It then waits for the downstream eigen_update_trig and reports completion, timeout and overrun status.

Parameters:
- MAX_LEN, 512: maximum number of elements per burst; sets the address range 0..MAX_LEN-1.
- RD_LAT, 2: DPRAM read latency in cycles, from rd_en/rd_addr to valid data; legal range 1..4.
- TIMEOUT_CYC, 1024: number of cycles spent in WAIT_RES before the timeout is declared.

Ports:
- sysClk  in  1  system clock; every register in the block is on its rising edge.
- reset  in  1  synchronous reset, active-high.
- trig  in  1  start-of-calculation strobe; sampled every cycle.
- vec_len  in  10  number of elements in the burst; latched on an accepted trig.
- result_done  in  1  eigen_update_trig returned from the downstream dot-product stage.
- rd_en  out  1  read enable to the Ut DPRAM port B and to the error RAM.
- rd_addr  out  9  read address, shared by both RAMs.
- ut_tvalid  out  1  multiplier operand-B valid (drives s_ut_tvalid_t).
- vec_tvalid  out  1  multiplier operand-A valid (drives eigen_vec_tvalid).
- vec_tlast  out  1  operand-A last (drives eigen_vec_tlast).
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse on normal completion.
- timeout  out  1  one-cycle pulse on timeout.
- lat_cnt  out  16  cycles from the accepted trig to result_done; holds the last completed value.
- overrun_cnt  out  16  saturating count of trig pulses that arrived while busy.

Behaviour:
- Reset values: every output is 0. State is IDLE. The valid/tlast delay pipeline is flushed.
- Reset mid-operation: the block returns to IDLE on the next cycle. Any in-flight valids are dropped, and lat_cnt and overrun_cnt are cleared.
- States:
  - IDLE
  - ISSUE
  - DRAIN
  - WAIT_RES
- Trigger acceptance (IDLE):
  - trig=1 with vec_len!=0 is accepted. The latched length is min(vec_len, MAX_LEN). Next state is ISSUE.
  - trig=1 with vec_len=0 is ignored: no state change, no pulse, no count.
- ISSUE, timing relative to an accepted trig in cycle T:
  - rd_en=1 and rd_addr=k in cycle T+1+k, for k = 0..len-1.
  - Addresses are contiguous with no gaps.
  - After the last address the state moves to DRAIN.
- Strobe alignment:
  - ut_tvalid and vec_tvalid are rd_en delayed by exactly RD_LAT cycles; the two are always identical.
  - vec_tlast is 1 only together with the valid for element len-1.
- DRAIN: lasts RD_LAT cycles, until the last valid has been emitted. Then the state moves to WAIT_RES.
- WAIT_RES:
  - result_done=1 → done pulses for one cycle, lat_cnt latches the cycle count since T, and the state returns to IDLE.
  - TIMEOUT_CYC cycles in WAIT_RES without result_done → timeout pulses for one cycle, lat_cnt is unchanged, and the state returns to IDLE.
  - result_done and the timeout terminal count in the same cycle → done wins.
- Counters:
  - The lat_cnt accumulator saturates at 0xFFFF.
  - result_done in any state other than WAIT_RES is ignored.
- Overrun:
  - trig while busy increments overrun_cnt, saturating at 0xFFFF, and is otherwise ignored.
  - In the cycle done or timeout pulses, the state is still non-IDLE, so a trig in that cycle counts as an overrun.
  - A trig in the following cycle (IDLE) is accepted.
- Address wrap: the address never wraps within a burst, because len ≤ MAX_LEN. Each burst restarts at 0.
- Downstream assumption: the multiplier ready is always 1, so there is no backpressure; rd_en is never stalled.

Test Plan:
1. Basic burst (RD_LAT=2, vec_len=4, trig at T, result_done at T+20):
   - rd_addr 0,1,2,3 with rd_en in T+1..T+4.
   - Both valids in T+3..T+6; vec_tlast in T+6 only.
   - done in T+20 (the cycle result_done is seen); lat_cnt=20; busy low from T+21.
2. Full length (vec_len=600):
   - Clipped to 512 addresses, 0..511, no wrap.
   - vec_tlast coincides with element 511.
   - Total valid count = 512.
3. Overrun:
   - Three trig pulses during ISSUE → overrun_cnt=3, burst unaffected.
   - trig in the done cycle → overrun_cnt=4.
   - trig one cycle after done → new burst starts.
4. Timeout (vec_len=8, result_done never asserted):
   - timeout pulse exactly TIMEOUT_CYC=1024 cycles after entering WAIT_RES.
   - done stays 0 and lat_cnt is unchanged.
   - A subsequent trig is accepted.
5. Reset mid-ISSUE (reset at element 5 of 16):
   - All outputs 0 on the next cycle; no further valids or tlast.
   - Counters are 0.
   - A trig after reset starts cleanly at address 0.
6. Corner cases:
   - vec_len=0 with trig → no activity, busy stays 0.
   - vec_len=1 → a single valid with vec_tlast=1 in the same cycle.
   - Sweep RD_LAT over 1..4 and check alignment for each value.
